// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if: operand/result handshake bundle for cla_pipe_adder
interface cla_pipe_adder_if #(parameter int WIDTH = 32);
   logic in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
   logic [WIDTH-1:0] a, b, sum;
   modport master (
      output in_valid, a, b, ci, sub, out_ready,
      input  in_ready, out_valid, sum, co, ovf
   );
   modport slave (
      input  in_valid, a, b, ci, sub, out_ready,
      output in_ready, out_valid, sum, co, ovf
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined segmented carry-lookahead adder/subtractor, one segment per stage
module cla_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int SEG = 8
) (
   input logic clk,
   input logic rst,
   cla_pipe_adder_if.slave bus
);
   localparam int S = WIDTH / SEG;
   logic [WIDTH-1:0] bx;
   logic [S-1:0] v, ld;
   assign bx = bus.b ^ {WIDTH{bus.sub}};
   // each stage may load when it is empty or everything downstream moves
   always_comb begin
      logic go;
      go = bus.out_ready;
      ld = '0;
      for (int k = S - 1; k >= 0; k--) begin
         go = !v[k] || go;
         ld[k] = go;
      end
   end
   assign bus.in_ready = ld[0];
   for (genvar k = 0; k < S; k++) begin : g_st
      localparam int L = k * SEG;
      logic [WIDTH-1:0] ua, an, a_q;
      logic [WIDTH-L-1:0] ub;
      logic [SEG-1:0] g, p, s;
      logic uc, uv, cn, v_q, c_q;
      if (k == 0) begin : g_src
         assign ua = bus.a;
         assign ub = bx;
         assign uc = bus.sub | bus.ci;
         assign uv = bus.in_valid;
      end else begin : g_src
         assign ua = g_st[k-1].a_q;
         assign ub = g_st[k-1].g_b.b_q;
         assign uc = g_st[k-1].c_q;
         assign uv = g_st[k-1].v_q;
      end
      assign g = ua[L +: SEG] & ub[SEG-1:0];
      assign p = ua[L +: SEG] ^ ub[SEG-1:0];
      always_comb begin
         logic cc;
         cc = uc;
         s = '0;
         for (int i = 0; i < SEG; i++) begin
            s[i] = p[i] ^ cc;
            cc = g[i] | (p[i] & cc);
         end
         cn = cc;
         an = ua;
         an[L +: SEG] = s;
      end
      always_ff @(posedge clk)
         if (rst) begin
            v_q <= 1'b0;
            a_q <= '0;
            c_q <= 1'b0;
         end else if (ld[k]) begin
            v_q <= uv;
            if (uv) begin
               a_q <= an;
               c_q <= cn;
            end
         end
      assign v[k] = v_q;
      if (k < S - 1) begin : g_b
         logic [WIDTH-L-SEG-1:0] b_q;
         always_ff @(posedge clk)
            if (rst) b_q <= '0;
            else if (ld[k] && uv) b_q <= ub[WIDTH-L-1:SEG];
      end else begin : g_m
         // carry into the MSB recovered from its sum and propagate bits
         logic m_q;
         always_ff @(posedge clk)
            if (rst) m_q <= 1'b0;
            else if (ld[k] && uv) m_q <= s[SEG-1] ^ p[SEG-1];
      end
   end
   assign bus.out_valid = g_st[S-1].v_q;
   assign bus.sum = g_st[S-1].a_q;
   assign bus.co = g_st[S-1].c_q;
   assign bus.ovf = g_st[S-1].g_m.m_q ^ g_st[S-1].c_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: randomized scoreboard bench for cla_pipe_adder
module tb_cla_pipe_adder;
   localparam int WIDTH = 32, SEG = 8, S = WIDTH / SEG;
   typedef struct {
      logic [WIDTH-1:0] sum;
      logic co, ovf, lat;
      int t;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1;
   cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();
   cla_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   exp_t q[$];
   exp_t nxt, got;
   int cyc = 0, checks = 0, passed = 0, accepts = 0, stalls = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask
   // reference: true integer arithmetic, then reduce
   function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic ci, logic sub, logic lat);
      exp_t e;
      longint r, ur;
      r = sub ? longint'($signed(a)) - longint'($signed(b))
              : longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      ur = longint'(a) + longint'(b) + longint'(ci);
      e.sum = r[WIDTH-1:0];
      e.co = sub ? (a >= b) : (ur >= (64'sd1 <<< WIDTH));
      e.ovf = (r > (64'sd1 <<< (WIDTH - 1)) - 1) || (r < -(64'sd1 <<< (WIDTH - 1)));
      e.lat = lat;
      e.t = 0;
      return e;
   endfunction
   always @(negedge clk) begin
      if (rst) q.delete();
      else begin
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected output: got sum %h, required no output", bus.sum);
            end else if (bus.out_ready) begin
               got = q.pop_front();
               check("sum", bus.sum, got.sum);
               check("co", 32'(bus.co), 32'(got.co));
               check("ovf", 32'(bus.ovf), 32'(got.ovf));
               if (got.lat) check("latency", cyc - got.t, S);
            end else check("hold sum", bus.sum, q[0].sum);
         end
         if (bus.in_valid && bus.in_ready) begin
            nxt.t = cyc;
            q.push_back(nxt);
            accepts++;
         end
      end
   end
   task automatic send(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic ci, logic sub, exp_t e);
      int n = 0;
      bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub; nxt = e;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         stalls++; n++;
         @(negedge clk);
      end
      if (n == 100) begin
         checks++;
         $display("FAIL accept timeout: in_ready 0, required 1");
      end
      @(posedge clk); #1;
   endtask
   task automatic send_rand(logic lat);
      logic [WIDTH-1:0] a, b;
      logic ci, sub;
      a = $urandom; b = $urandom;
      ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      send(a, b, ci, sub, model(a, b, ci, sub, lat));
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk); n++;
      end
      check("drain", q.size(), 0);
      @(posedge clk); #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset out_valid", 32'(bus.out_valid), 0);
      check("reset sum", bus.sum, 0);
      check("reset co", 32'(bus.co), 0);
      check("reset ovf", 32'(bus.ovf), 0);
      check("reset in_ready", 32'(bus.in_ready), 1);
      @(posedge clk); #1;
      send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, exp_t'{sum: 32'h0, co: 1'b1, ovf: 1'b0, lat: 1'b1, t: 0});
      send(32'd5, 32'd7, 1'b0, 1'b1, exp_t'{sum: 32'hFFFF_FFFE, co: 1'b0, ovf: 1'b0, lat: 1'b1, t: 0});
      send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, exp_t'{sum: 32'h8000_0000, co: 1'b0, ovf: 1'b1, lat: 1'b1, t: 0});
      send(32'h8000_0000, 32'd1, 1'b1, 1'b1, exp_t'{sum: 32'h7FFF_FFFF, co: 1'b1, ovf: 1'b1, lat: 1'b1, t: 0});
      bus.in_valid = 1'b0;
      drain();
      stalls = 0;
      repeat (100) send_rand(1'b1);
      bus.in_valid = 1'b0;
      check("back-to-back stalls", stalls, 0);
      drain();
      bus.out_ready = 1'b0;
      accepts = 0;
      fork
         repeat (6) send_rand(1'b0);
         begin
            int n = 0;
            while (accepts < 4 && n < 50) begin
               @(posedge clk); n++;
            end
            @(negedge clk);
            check("full accepts", accepts, 4);
            check("full in_ready", 32'(bus.in_ready), 0);
            repeat (3) begin
               @(negedge clk);
               check("stalled in_ready", 32'(bus.in_ready), 0);
            end
            @(posedge clk); #1 bus.out_ready = 1'b1;
            @(negedge clk);
            check("release in_ready", 32'(bus.in_ready), 1);
         end
      join
      bus.in_valid = 1'b0;
      drain();
      check("backpressure accepts", accepts, 6);
      bus.out_ready = 1'b0;
      repeat (3) send_rand(1'b0);
      rst = 1'b1;
      bus.a = $urandom; bus.b = $urandom;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("mid reset out_valid", 32'(bus.out_valid), 0);
      check("mid reset sum", bus.sum, 0);
      repeat (10) @(negedge clk);
      check("mid reset queue", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
